// File: rtl/axi4_lite_write_slave_pkg.sv
// Shared constants and types for the AXI4-Lite write slave: BRESP codes,
// FSM state encoding and the strobe-width helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi4_lite_write_slave_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) with master and slave views.
interface axi4_lite_write_slave_if
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32
);

    logic [ADDRESS_WIDTH-1:0]                write_addr;
    logic                                    write_addr_valid;
    logic                                    write_addr_ready;
    logic [DATA_WIDTH-1:0]                   write_data;
    logic [strb_width(DATA_WIDTH)-1:0]       write_strb;
    logic                                    write_data_valid;
    logic                                    write_data_ready;
    logic [1:0]                              write_resp;
    logic                                    write_resp_valid;
    logic                                    write_resp_ready;

    modport master (
        output write_addr, write_addr_valid, write_data, write_strb, write_data_valid,
        output write_resp_ready,
        input  write_addr_ready, write_data_ready, write_resp, write_resp_valid
    );

    modport slave (
        input  write_addr, write_addr_valid, write_data, write_strb, write_data_valid,
        input  write_resp_ready,
        output write_addr_ready, write_data_ready, write_resp, write_resp_valid
    );

endinterface

// File: rtl/axi4_lite_write_slave_hold_slot.sv
// One-entry holding register: accepts on valid&ready, keeps the payload until
// cleared. Ready is forced low while reset is asserted.
module axi4_lite_hold_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    input  logic             clear_i,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;
    logic             accept;

    assign in_ready_o = ~full_q & rst_ni;
    assign accept     = in_valid_i & in_ready_o;
    assign full_o     = full_q;
    assign data_o     = data_q;

    // Clear only happens while full, so it never coincides with an accept.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write slave: independent AW/W slots, address/alignment decode,
// one backpressured downstream write at a time, then an OKAY/SLVERR response.
module axi4_lite_write_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_ADDR      = 'hFF
) (
    input  logic                              axi_clk,
    input  logic                              resetn,
    axi4_lite_write_slave_if.slave            axi,
    output logic [ADDRESS_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data,
    output logic [strb_width(DATA_WIDTH)-1:0] wr_strb,
    output logic                              wr_valid,
    input  logic                              wr_ready
);

    localparam int unsigned StrbWidth = strb_width(DATA_WIDTH);
    localparam int unsigned WWidth    = DATA_WIDTH + StrbWidth;

    state_t              state_q, state_d;
    logic [1:0]          resp_q, resp_d;
    logic                aw_full, w_full;
    logic                clear;
    logic                addr_err;
    logic [WWidth-1:0]   w_payload;

    axi4_lite_hold_slot #(
        .Width (ADDRESS_WIDTH)
    ) u_aw_slot (
        .clk_i      (axi_clk),
        .rst_ni     (resetn),
        .in_valid_i (axi.write_addr_valid),
        .in_ready_o (axi.write_addr_ready),
        .in_data_i  (axi.write_addr),
        .clear_i    (clear),
        .full_o     (aw_full),
        .data_o     (wr_addr)
    );

    axi4_lite_hold_slot #(
        .Width (WWidth)
    ) u_w_slot (
        .clk_i      (axi_clk),
        .rst_ni     (resetn),
        .in_valid_i (axi.write_data_valid),
        .in_ready_o (axi.write_data_ready),
        .in_data_i  ({axi.write_data, axi.write_strb}),
        .clear_i    (clear),
        .full_o     (w_full),
        .data_o     (w_payload)
    );

    assign wr_data = w_payload[WWidth-1:StrbWidth];
    assign wr_strb = w_payload[StrbWidth-1:0];

    // Low address bits below the bus width must be zero for an aligned access.
    assign addr_err = (32'(wr_addr) > MAX_ADDR) ||
                      ((32'(wr_addr) & (StrbWidth - 1)) != 32'd0);

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (aw_full && w_full) begin
                    if (addr_err) begin
                        state_d = RESP;
                        resp_d  = RESP_SLVERR;
                        clear   = 1'b1;
                    end else if (wr_strb == '0) begin
                        state_d = RESP;
                        resp_d  = RESP_OKAY;
                        clear   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    state_d = RESP;
                    resp_d  = RESP_OKAY;
                    clear   = 1'b1;
                end
            end
            RESP: begin
                if (axi.write_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    assign wr_valid             = (state_q == ISSUE);
    assign axi.write_resp_valid = (state_q == RESP);
    assign axi.write_resp       = resp_q;

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Directed bench for axi4_lite_write_slave (ADDRESS_WIDTH=9, DATA_WIDTH=32, MAX_ADDR=0xFF).
module tb_axi4_lite_write_slave;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          resetn;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
    logic          wr_valid;
    logic          wr_ready;

    int n_assert = 0;
    int n_fail   = 0;

    axi4_lite_write_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4_lite_write_slave #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_ADDR      ('hFF)
    ) dut (
        .axi_clk  (clk),
        .resetn   (resetn),
        .axi      (axi),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_aw(input logic [AW-1:0] a);
        axi.write_addr       = a;
        axi.write_addr_valid = 1'b1;
    endtask

    task automatic put_w(input logic [DW-1:0] d, input logic [3:0] s);
        axi.write_data       = d;
        axi.write_strb       = s;
        axi.write_data_valid = 1'b1;
    endtask

    task automatic drop_valids();
        axi.write_addr_valid = 1'b0;
        axi.write_data_valid = 1'b0;
    endtask

    initial begin
        resetn               = 1'b0;
        wr_ready             = 1'b1;
        axi.write_addr       = '0;
        axi.write_addr_valid = 1'b0;
        axi.write_data       = '0;
        axi.write_strb       = '0;
        axi.write_data_valid = 1'b0;
        axi.write_resp_ready = 1'b1;
        #1;
        chk("rst_awready", axi.write_addr_ready, 0);
        chk("rst_wready", axi.write_data_ready, 0);
        chk("rst_bvalid", axi.write_resp_valid, 0);
        chk("rst_bresp", axi.write_resp, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_payload", {wr_addr, wr_data, wr_strb}, 0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rel_awready", axi.write_addr_ready, 1);
        chk("rel_wready", axi.write_data_ready, 1);

        // AW and W in the same cycle, everything downstream ready.
        tick();
        put_aw(9'h010);
        put_w(32'hDEADBEEF, 4'hF);
        tick();
        drop_valids();
        chk("t1_e0_awready", axi.write_addr_ready, 0);
        chk("t1_e0_wr_valid", wr_valid, 0);
        tick();
        chk("t1_e1_wr_valid", wr_valid, 1);
        chk("t1_e1_wr_addr", wr_addr, 9'h010);
        chk("t1_e1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_e1_bvalid", axi.write_resp_valid, 0);
        tick();
        chk("t1_e2_bvalid", axi.write_resp_valid, 1);
        chk("t1_e2_bresp", axi.write_resp, 2'b00);
        chk("t1_e2_wr_valid", wr_valid, 0);
        chk("t1_e2_awready", axi.write_addr_ready, 1);
        tick();
        chk("t1_e3_bvalid", axi.write_resp_valid, 0);

        // W three cycles ahead of AW, partial strobe.
        put_w(32'h11223344, 4'b0101);
        tick();
        axi.write_data_valid = 1'b0;
        chk("t2_wready_drop", axi.write_data_ready, 0);
        chk("t2_awready_hold", axi.write_addr_ready, 1);
        tick();
        tick();
        put_aw(9'h008);
        tick();
        drop_valids();
        tick();
        chk("t2_wr_valid", wr_valid, 1);
        chk("t2_wr_addr", wr_addr, 9'h008);
        chk("t2_wr_strb", wr_strb, 4'b0101);
        chk("t2_wr_data", wr_data, 32'h11223344);
        tick();
        chk("t2_bvalid", axi.write_resp_valid, 1);
        chk("t2_bresp", axi.write_resp, 2'b00);
        tick();

        // Unaligned address -> SLVERR one cycle after slots fill.
        put_aw(9'h00E);
        put_w(32'h0, 4'hF);
        tick();
        drop_valids();
        chk("t3a_wr_valid0", wr_valid, 0);
        tick();
        chk("t3a_bvalid", axi.write_resp_valid, 1);
        chk("t3a_bresp", axi.write_resp, 2'b10);
        chk("t3a_wr_valid1", wr_valid, 0);
        chk("t3a_awready", axi.write_addr_ready, 1);
        tick();
        chk("t3a_bdone", axi.write_resp_valid, 0);

        // Address above MAX_ADDR -> SLVERR.
        put_aw(9'h100);
        put_w(32'h0, 4'hF);
        tick();
        drop_valids();
        tick();
        chk("t3b_bvalid", axi.write_resp_valid, 1);
        chk("t3b_bresp", axi.write_resp, 2'b10);
        chk("t3b_wr_valid", wr_valid, 0);
        tick();

        // All-zero strobe -> OKAY with no downstream write.
        put_aw(9'h020);
        put_w(32'h5A5A5A5A, 4'h0);
        tick();
        drop_valids();
        tick();
        chk("t3c_bvalid", axi.write_resp_valid, 1);
        chk("t3c_bresp", axi.write_resp, 2'b00);
        chk("t3c_wr_valid", wr_valid, 0);
        tick();

        // Downstream backpressure; a second AW/W waits behind the first.
        wr_ready = 1'b0;
        put_aw(9'h024);
        put_w(32'hCAFEF00D, 4'h3);
        tick();
        drop_valids();
        tick();
        chk("t4_wr_valid", wr_valid, 1);
        put_aw(9'h028);
        put_w(32'h00000055, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_awready", axi.write_addr_ready, 0);
            chk("t4_stall_payload", {wr_valid, wr_addr, wr_data, wr_strb},
                {1'b1, 9'h024, 32'hCAFEF00D, 4'h3});
            tick();
        end
        wr_ready = 1'b1;
        tick();
        chk("t4_bvalid", axi.write_resp_valid, 1);
        chk("t4_wr_done", wr_valid, 0);
        chk("t4_awready_free", axi.write_addr_ready, 1);
        tick();
        drop_valids();
        chk("t4_second_taken", axi.write_addr_ready, 0);
        chk("t4_bdone", axi.write_resp_valid, 0);
        tick();
        chk("t4_second_wr_valid", wr_valid, 1);
        chk("t4_second_wr_addr", wr_addr, 9'h028);
        tick();
        tick();

        // BREADY held low; next pair accepted during RESP.
        axi.write_resp_ready = 1'b0;
        put_aw(9'h030);
        put_w(32'h0A0B0C0D, 4'hF);
        tick();
        drop_valids();
        tick();
        tick();
        chk("t5_bvalid", axi.write_resp_valid, 1);
        put_aw(9'h034);
        put_w(32'h00000099, 4'hF);
        tick();
        drop_valids();
        chk("t5_accept_in_resp", axi.write_addr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_b_stable", {axi.write_resp_valid, axi.write_resp}, {1'b1, 2'b00});
            chk("t5_no_issue", wr_valid, 0);
            if (i < 2) tick();
        end
        axi.write_resp_ready = 1'b1;
        tick();
        chk("t5_bdone", axi.write_resp_valid, 0);
        chk("t5_idle_wr_valid", wr_valid, 0);
        tick();
        chk("t5_next_wr_valid", wr_valid, 1);
        chk("t5_next_wr_addr", wr_addr, 9'h034);
        tick();
        tick();

        // Reset pulse while a write is waiting in ISSUE.
        wr_ready = 1'b0;
        put_aw(9'h038);
        put_w(32'h77777777, 4'hF);
        tick();
        drop_valids();
        tick();
        chk("t6_issue", wr_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_wr_valid", wr_valid, 0);
        chk("t6_rst_bvalid", axi.write_resp_valid, 0);
        chk("t6_rst_readys", {axi.write_addr_ready, axi.write_data_ready}, 0);
        chk("t6_rst_payload", {wr_addr, wr_data, wr_strb}, 0);
        tick();
        resetn   = 1'b1;
        wr_ready = 1'b1;
        #1;
        chk("t6_rel_readys", {axi.write_addr_ready, axi.write_data_ready}, 2'b11);
        chk("t6_rel_bvalid", axi.write_resp_valid, 0);
        put_aw(9'h004);
        put_w(32'h12345678, 4'hF);
        tick();
        drop_valids();
        tick();
        chk("t6_new_wr_addr", {wr_valid, wr_addr}, {1'b1, 9'h004});
        tick();
        chk("t6_new_b", {axi.write_resp_valid, axi.write_resp}, {1'b1, 2'b00});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
